// File: rtl/johnson_pkg.sv
// Shared widths, FSM state encoding, decode result type and the Johnson encode helper
// for the phase tracker.
package johnson_pkg;

    localparam int unsigned JC_W   = 8;
    localparam int unsigned NPHASE = 16;
    localparam int unsigned PH_W   = $clog2(NPHASE);
    localparam int unsigned CNT_W  = PH_W + 1;
    localparam int unsigned ERR_W  = 8;

    // 2'd3 is never entered; the FSM treats it as SEARCH.
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } track_state_e;

    typedef struct packed {
        logic            legal;
        logic [PH_W-1:0] phase;
    } jc_dec_t;

    // Phases 0..8 fill ones from the MSB down; phases 9..15 drain them from the MSB.
    function automatic logic [JC_W-1:0] jc_encode(input logic [PH_W-1:0] p);
        logic [JC_W-1:0] code;
        int unsigned     pi;
        pi   = 32'(p);
        code = '0;
        for (int unsigned i = 0; i < JC_W; i++) begin
            code[3'(JC_W - 1 - i)] = (pi <= JC_W) ? (i < pi) : (i >= (pi - JC_W));
        end
        return code;
    endfunction

endpackage

// File: rtl/johnson_phase_tracker_if.sv
// Sample input and tracker result signals between the Johnson counter stage and its consumer.
interface johnson_phase_tracker_if;
    import johnson_pkg::*;

    logic             ena;
    logic [JC_W-1:0]  jc_in;
    logic [PH_W-1:0]  phase;
    logic             phase_vld;
    logic             illegal;
    logic             seq_err;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output ena, jc_in,
        input  phase, phase_vld, illegal, seq_err, locked, err_cnt
    );

    modport slave (
        input  ena, jc_in,
        output phase, phase_vld, illegal, seq_err, locked, err_cnt
    );

endinterface

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code decoder: popcount picks the candidate phase, re-encoding
// the candidate confirms that the code is one of the 16 legal patterns.
module johnson_code_decode
    import johnson_pkg::*;
(
    input  logic [JC_W-1:0] jc_in,
    output jc_dec_t         dec_c
);

    logic [CNT_W-1:0] ones;
    logic [PH_W-1:0]  cand;

    always_comb begin
        ones = CNT_W'($countones(jc_in));
        if (jc_in[JC_W-1] || (jc_in == '0)) begin
            cand = PH_W'(ones);
        end else begin
            cand = PH_W'(CNT_W'(NPHASE) - ones);
        end
        dec_c.phase = cand;
        dec_c.legal = (jc_encode(cand) == jc_in);
    end

endmodule

// File: rtl/johnson_phase_tracker.sv
// Johnson counter stream tracker: decode, sequence check, SEARCH/CONFIRM/LOCKED lock FSM.
// Define JOHNSON_TRACK_ERRCNT_EN to build the saturating in-lock fault counter.
module johnson_phase_tracker
    import johnson_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    johnson_phase_tracker_if.slave  bus
);

    jc_dec_t         dec_c;
    track_state_e    state_q, state_d;
    logic [3:0]      good_cnt_q, good_cnt_d;
    logic [3:0]      bad_cnt_q, bad_cnt_d;
    logic [PH_W-1:0] pred_q, pred_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            phase_vld_q, phase_vld_d;
    logic            illegal_q, illegal_d;
    logic            seq_err_q, seq_err_d;
    logic            locked_q, locked_d;
    logic [PH_W-1:0] exp_lk_c, exp_cf_c;

    johnson_code_decode u_decode (
        .jc_in (bus.jc_in),
        .dec_c (dec_c)
    );

    // phase_q doubles as the last legal phase that CONFIRM extrapolates from.
    assign exp_lk_c = pred_q + PH_W'(1);
    assign exp_cf_c = phase_q + PH_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            pred_q      <= '0;
            phase_q     <= '0;
            phase_vld_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            pred_q      <= pred_d;
            phase_q     <= phase_d;
            phase_vld_q <= phase_vld_d;
            illegal_q   <= illegal_d;
            seq_err_q   <= seq_err_d;
            locked_q    <= locked_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        pred_d      = pred_q;
        phase_d     = phase_q;
        phase_vld_d = 1'b0;
        illegal_d   = 1'b0;
        seq_err_d   = 1'b0;

        if (bus.ena) begin
            phase_vld_d = dec_c.legal;
            illegal_d   = !dec_c.legal;
            if (dec_c.legal) begin
                phase_d = dec_c.phase;
            end

            case (state_q)
                SEARCH: begin
                    if (dec_c.legal) begin
                        state_d    = CONFIRM;
                        good_cnt_d = 4'd1;
                    end
                end
                CONFIRM: begin
                    if (!dec_c.legal) begin
                        state_d    = SEARCH;
                        good_cnt_d = '0;
                    end else if (dec_c.phase == exp_cf_c) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if ((good_cnt_q + 4'd1) == 4'(LOCK_CNT)) begin
                            state_d   = LOCKED;
                            pred_d    = dec_c.phase;
                            bad_cnt_d = '0;
                        end
                    end else begin
                        seq_err_d  = 1'b1;
                        good_cnt_d = 4'd1;
                    end
                end
                LOCKED: begin
                    if (dec_c.legal && (dec_c.phase == exp_lk_c)) begin
                        bad_cnt_d = '0;
                        pred_d    = dec_c.phase;
                    end else begin
                        // Coast the predictor so a single glitch does not shift the expectation.
                        seq_err_d = dec_c.legal;
                        pred_d    = exp_lk_c;
                        if ((bad_cnt_q + 4'd1) == 4'(LOSS_CNT)) begin
                            state_d    = SEARCH;
                            bad_cnt_d  = '0;
                            good_cnt_d = '0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d    = SEARCH;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    assign bus.phase     = phase_q;
    assign bus.phase_vld = phase_vld_q;
    assign bus.illegal   = illegal_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.locked    = locked_q;

`ifdef JOHNSON_TRACK_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt_q;
    logic             lk_bad_c;

    // Every bad sample in LOCKED counts, including the one that drops the lock.
    assign lk_bad_c = bus.ena && (state_q == LOCKED) &&
                      !(dec_c.legal && (dec_c.phase == exp_lk_c));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (lk_bad_c && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Scoreboard bench for johnson_phase_tracker: a table-driven reference model pushes the
// expected outputs for every driven cycle, each scenario task pops and compares them.
module tb_johnson_phase_tracker;

    localparam int unsigned LOCK = 4;
    localparam int unsigned LOSS = 2;
`ifdef JOHNSON_TRACK_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] phase;
        logic       vld;
        logic       ill;
        logic       seq;
        logic       lck;
        logic [7:0] err;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];

    logic [7:0] jc_tab [16];

    int m_state, m_good, m_bad, m_pred, m_phase, m_err;

    johnson_phase_tracker_if bus();

    johnson_phase_tracker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t o;
        o.phase = bus.phase;
        o.vld   = bus.phase_vld;
        o.ill   = bus.illegal;
        o.seq   = bus.seq_err;
        o.lck   = bus.locked;
        o.err   = bus.err_cnt;
        return o;
    endfunction

    // Reference model: decodes by searching the literal code table.
    task automatic model(input logic e, input logic [7:0] c, input logic rst);
        obs_t x;
        bit   legal;
        int   ph;
        x = '0;
        if (rst) begin
            m_state = 0; m_good = 0; m_bad = 0; m_pred = 0; m_phase = 0; m_err = 0;
        end else if (e) begin
            legal = 1'b0;
            ph    = 0;
            for (int p = 0; p < 16; p++) begin
                if (jc_tab[p] == c) begin
                    legal = 1'b1;
                    ph    = p;
                end
            end
            x.vld = legal;
            x.ill = !legal;
            case (m_state)
                0: if (legal) begin m_state = 1; m_good = 1; end
                1: begin
                    if (!legal) begin
                        m_state = 0; m_good = 0;
                    end else if (ph == (m_phase + 1) % 16) begin
                        m_good++;
                        if (m_good == LOCK) begin m_state = 2; m_pred = ph; m_bad = 0; end
                    end else begin
                        x.seq = 1'b1; m_good = 1;
                    end
                end
                default: begin
                    if (legal && ph == (m_pred + 1) % 16) begin
                        m_bad = 0; m_pred = ph;
                    end else begin
                        x.seq  = legal;
                        m_pred = (m_pred + 1) % 16;
                        if (ERR_EN && m_err < 255) m_err++;
                        m_bad++;
                        if (m_bad == LOSS) begin m_state = 0; m_bad = 0; m_good = 0; end
                    end
                end
            endcase
            if (legal) m_phase = ph;
        end
        if (!rst) begin
            x.phase = 4'(m_phase);
            x.lck   = (m_state == 2);
            x.err   = 8'(m_err);
        end
        sb.push_back(x);
    endtask

    task automatic step(input logic e, input logic [7:0] c, input logic rst);
        @(negedge clk);
        rst_n      = !rst;
        bus.ena    = e;
        bus.jc_in  = c;
        model(e, c, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t exp, act;
        step(1'b1, 8'hC0, 1'b1);
        exp = sb.pop_front();
        act = sample();
        checks++;
        if (act !== exp) begin errors++; $display("FAIL reset_sb got %h want %h", act, exp); end
        checks++;
        if (act !== obs_t'(0)) begin errors++; $display("FAIL reset_zero got %h want 0", act); end
    endtask

    task automatic test_lock();
        obs_t exp, act;
        logic [7:0] codes [4];
        codes = '{8'h00, 8'h80, 8'hC0, 8'hE0};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, codes[i], 1'b0);
            exp = sb.pop_front();
            act = sample();
            checks++;
            if (act !== exp) begin errors++; $display("FAIL lock[%0d] got %h want %h", i, act, exp); end
            checks++;
            if (act.phase !== 4'(i) || act.vld !== 1'b1 || act.seq !== 1'b0 || act.lck !== (i == 3)) begin
                errors++;
                $display("FAIL lock_const[%0d] phase=%0d vld=%b seq=%b lck=%b want phase=%0d vld=1 seq=0 lck=%b",
                         i, act.phase, act.vld, act.seq, act.lck, i, (i == 3));
            end
        end
    endtask

    task automatic test_illegal();
        obs_t exp, act;
        step(1'b1, 8'hA5, 1'b0);
        exp = sb.pop_front();
        act = sample();
        checks++;
        if (act !== exp) begin errors++; $display("FAIL illegal_sb got %h want %h", act, exp); end
        checks++;
        if (act.ill !== 1'b1 || act.vld !== 1'b0 || act.lck !== 1'b1 || act.phase !== 4'd3) begin
            errors++; $display("FAIL illegal_const got %h want ill=1 vld=0 lck=1 phase=3", act);
        end
        step(1'b1, 8'hF8, 1'b0);
        exp = sb.pop_front();
        act = sample();
        checks++;
        if (act !== exp) begin errors++; $display("FAIL illegal_recover_sb got %h want %h", act, exp); end
        checks++;
        if (act.phase !== 4'd5 || act.lck !== 1'b1 || act.ill !== 1'b0 || act.err !== (ERR_EN ? 8'd1 : 8'd0)) begin
            errors++; $display("FAIL illegal_recover_const got %h want phase=5 lck=1 err=%0d", act, ERR_EN);
        end
    endtask

    task automatic test_hold_loss();
        obs_t exp, act;
        logic [7:0] codes [9];
        codes = '{8'hFC, 8'hFE, 8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h0F, 8'h0F};
        for (int i = 0; i < 9; i++) begin
            step(1'b1, codes[i], 1'b0);
            exp = sb.pop_front();
            act = sample();
            checks++;
            if (act !== exp) begin errors++; $display("FAIL hold[%0d] got %h want %h", i, act, exp); end
        end
        checks++;
        if (act.seq !== 1'b1 || act.lck !== 1'b0 || act.err !== (ERR_EN ? 8'd3 : 8'd0)) begin
            errors++; $display("FAIL hold_loss_const got %h want seq=1 lck=0 err=%0d", act, ERR_EN ? 3 : 0);
        end
    endtask

    task automatic test_wrap();
        obs_t exp, act;
        logic [7:0] codes [8];
        codes = '{8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h80};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, codes[i], 1'b0);
            exp = sb.pop_front();
            act = sample();
            checks++;
            if (act !== exp) begin errors++; $display("FAIL wrap[%0d] got %h want %h", i, act, exp); end
            checks++;
            if (act.seq !== 1'b0) begin errors++; $display("FAIL wrap_seq[%0d] got seq=%b want 0", i, act.seq); end
        end
        checks++;
        if (act.phase !== 4'd1 || act.lck !== 1'b1) begin
            errors++; $display("FAIL wrap_end got phase=%0d lck=%b want phase=1 lck=1", act.phase, act.lck);
        end
    endtask

    task automatic test_ena_gap();
        obs_t exp, act;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'($urandom_range(0, 255)), 1'b0);
            exp = sb.pop_front();
            act = sample();
            checks++;
            if (act !== exp) begin errors++; $display("FAIL gap[%0d] got %h want %h", i, act, exp); end
            checks++;
            if (act.vld !== 1'b0 || act.ill !== 1'b0 || act.seq !== 1'b0) begin
                errors++; $display("FAIL gap_pulse[%0d] got %h want no pulses", i, act);
            end
        end
        step(1'b1, 8'hC0, 1'b0);
        exp = sb.pop_front();
        act = sample();
        checks++;
        if (act !== exp) begin errors++; $display("FAIL gap_resume got %h want %h", act, exp); end
        checks++;
        if (act.seq !== 1'b0 || act.phase !== 4'd2 || act.lck !== 1'b1) begin
            errors++; $display("FAIL gap_resume_const got %h want seq=0 phase=2 lck=1", act);
        end
    endtask

    task automatic test_back_to_back();
        obs_t exp, act;
        logic [7:0] codes [4];
        codes = '{8'h55, 8'hF0, 8'h55, 8'hFC};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, codes[i], 1'b0);
            exp = sb.pop_front();
            act = sample();
            checks++;
            if (act !== exp) begin errors++; $display("FAIL b2b[%0d] got %h want %h", i, act, exp); end
        end
        checks++;
        if (act.lck !== 1'b1 || act.err !== (ERR_EN ? 8'd5 : 8'd0)) begin
            errors++; $display("FAIL b2b_err got lck=%b err=%0d want lck=1 err=%0d", act.lck, act.err, ERR_EN ? 5 : 0);
        end
        step(1'b1, 8'hFE, 1'b1);
        exp = sb.pop_front();
        act = sample();
        checks++;
        if (act !== exp) begin errors++; $display("FAIL midreset_sb got %h want %h", act, exp); end
        checks++;
        if (act !== obs_t'(0)) begin errors++; $display("FAIL midreset_zero got %h want 0", act); end
    endtask

    task automatic test_random();
        obs_t exp, act;
        int p, r;
        logic e;
        logic [7:0] c;
        p = 15;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            e = 1'b1;
            if (r <= 6) begin
                p = (p + 1) % 16; c = jc_tab[p];
            end else if (r == 7) begin
                c = 8'($urandom_range(0, 255));
            end else if (r == 8) begin
                e = 1'b0; c = 8'($urandom_range(0, 255));
            end else begin
                p = $urandom_range(0, 15); c = jc_tab[p];
            end
            step(e, c, 1'b0);
            exp = sb.pop_front();
            act = sample();
            checks++;
            if (act !== exp) begin errors++; $display("FAIL rand[%0d] code=%h ena=%b got %h want %h", i, c, e, act, exp); end
        end
    endtask

    initial begin
        jc_tab = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE,
                   8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
        bus.ena   = 1'b0;
        bus.jc_in = 8'h00;
        test_reset();
        test_lock();
        test_illegal();
        test_hold_loss();
        test_wrap();
        test_ena_gap();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
